data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the pipeline's data-memory interface. The CPU MEM stage initiates loads and stores; this block accepts each request, inserts a programmable number of wait states, and then commits the store or returns the load data. Each transaction completes with a one-cycle acknowledge. It replaces the zero-latency data RAM when the team models slower memory. Storage is byte-addressed and big-endian, with byte, halfword and word access.

## Interface
Parameters:
- ADDR_W, 8, byte-address width
- DEPTH, 256, bytes of storage (2**ADDR_W)
- WAIT_STATES, 1, extra cycles per access, legal range 0..7

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  reset; one clock; reset is asynchronous and active-low
- REQ  in  1  request valid; held with stable request fields until ACK
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- SE  in  1  sign-extend byte/halfword loads
- ADDR  in  ADDR_W  byte address
- DI  in  32  store data, right-justified
- ACK  out  1  one-cycle completion pulse
- ERR  out  1  valid with ACK; request rejected
- DO  out  32  load data, right-justified
- BUSY  out  1  transaction in progress (state != IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, REQ=1 at a rising edge: latch WE, SIZE, SE, ADDR, DI and load the wait counter with WAIT_STATES.
  - WAIT_STATES=0: perform the access at this edge and go to RESP.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter reaches 0, perform the access and go to RESP.
- RESP: ACK=1 for exactly one cycle, then unconditionally return to IDLE. A REQ sampled high in IDLE starts a new transaction, so back-to-back requests are legal.
- Access semantics, big-endian (Mem[a] is the most significant byte):
  - Byte store: DI[7:0] is written to Mem[a].
  - Halfword store: DI[15:8] to Mem[a], DI[7:0] to Mem[a+1].
  - Word store: DI[31:24] to Mem[a] … DI[7:0] to Mem[a+3].
  - Loads assemble the same byte order, then zero-extend, or sign-extend from bit 7 or bit 15 when SE=1. SE is ignored for word loads.
- Error conditions:
  - Triggers: SIZE=11, halfword with ADDR[0]=1, or word with ADDR[1:0]≠00.
  - Response: no memory write, DO loaded with 0, and ERR=1 together with ACK after the normal latency.
- DO is updated only at the access edge, for loads and for erroring requests. It holds its value across stores and idle cycles.
- REQ dropping while in WAIT does not abort the transaction.

## Timing
- Reset values: state IDLE, ACK=0, ERR=0, DO=0, BUSY=0, counter 0.
- Memory contents are not cleared by reset; the bench preloads them hierarchically.
- Latency: with the request accepted at edge E0, the access occurs at edge E0+WAIT_STATES. ACK is high in the cycle following that edge. Throughput is one transaction per WAIT_STATES+2 cycles.
- BUSY goes high in the cycle after acceptance and stays high through the RESP cycle.
- ERR is 0 whenever ACK is 0.
- Reset asserted during WAIT: the transaction is discarded, no write occurs, and ACK is never issued.
- Reset asserted during RESP: ACK drops immediately, asynchronously.
- Address wrap-around: none. In-range aligned accesses never cross DEPTH, because alignment is enforced.

## Structure
- Shared package holds:
  - SIZE encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state encoding.
  - Alignment-check function, reused by the CPU-side bench.
- Sub-module data_mem_array: DEPTH×8 storage with 4-lane big-endian write enables and a combinational 4-byte read at the base address. The FSM and extension logic live in the top module.

## Test plan
- WAIT_STATES=1: word store ADDR=0x10, DI=0xDEADBEEF. Expected: ACK in the 2nd cycle after acceptance, ERR=0, Mem[0x10..0x13]=DE AD BE EF. A word load of 0x10 then returns DO=0xDEADBEEF.
- Byte load ADDR=0x11 (0xAD): with SE=1, DO=0xFFFFFFAD; with SE=0, DO=0x000000AD. Halfword load ADDR=0x12, SE=1 returns DO=0xFFFFBEEF.
- Misaligned word load ADDR=0x13 and SIZE=11 store: each yields ERR=1 with ACK, DO=0, and memory unchanged.
- WAIT_STATES=0 back-to-back: byte store ADDR=0x20, DI=0x5A, then REQ held for a byte load of 0x20. Expected: ACKs 2 cycles apart, second DO=0x0000005A.
- Store to ADDR=0x30 with WAIT_STATES=3, RST pulled low mid-WAIT. Expected: ACK never asserted, Mem[0x30] unchanged, outputs at reset values, and the next request is serviced normally.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM state encoding and the alignment rule also used by CPU-side benches.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // True when the request must be rejected: illegal size or a halfword/word
    // that does not sit on its natural boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-wide storage with four big-endian write lanes (lane 0 = lowest address)
// and a combinational 4-byte read starting at the base address.
module data_mem_array #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        lane_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[addr + ADDR_W'(i)] <= wdata[31-8*i -: 8];
            end
        end
    end

    assign rdata = {mem[addr], mem[addr + ADDR_W'(1)], mem[addr + ADDR_W'(2)], mem[addr + ADDR_W'(3)]};

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles,
// performs the big-endian access and acknowledges for one cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              SE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DI,
    output logic              ACK,
    output logic              ERR,
    output logic [31:0]       DO,
    output logic              BUSY
);

    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    state_t            state, next_state;
    logic [2:0]        cnt;
    logic              we_q, se_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       di_q;

    logic              access, load_fields, acc_err;
    logic              cur_we, cur_se;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_di, wdata, rdata, load_val;
    logic [3:0]        lane_we;

    // With zero wait states the access happens at the accept edge, so the
    // live request fields are used instead of the not-yet-latched copies.
    assign cur_we   = (state == S_IDLE) ? WE   : we_q;
    assign cur_se   = (state == S_IDLE) ? SE   : se_q;
    assign cur_size = (state == S_IDLE) ? SIZE : size_q;
    assign cur_addr = (state == S_IDLE) ? ADDR : addr_q;
    assign cur_di   = (state == S_IDLE) ? DI   : di_q;
    assign acc_err  = is_misaligned(cur_size, cur_addr[1:0]);

    always_comb begin
        next_state  = state;
        access      = 1'b0;
        load_fields = 1'b0;
        case (state)
            S_IDLE: begin
                if (REQ) begin
                    load_fields = 1'b1;
                    if (WS_INIT == 3'd0) begin
                        access     = 1'b1;
                        next_state = S_RESP;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd1) begin
                    access     = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Store lanes and load extension; writes are suppressed while reset is held.
    always_comb begin
        lane_we  = 4'b0000;
        wdata    = cur_di;
        load_val = rdata;
        case (cur_size)
            SZ_BYTE: begin
                lane_we  = 4'b0001;
                wdata    = {cur_di[7:0], 24'h0};
                load_val = {{24{cur_se & rdata[31]}}, rdata[31:24]};
            end
            SZ_HALF: begin
                lane_we  = 4'b0011;
                wdata    = {cur_di[15:0], 16'h0};
                load_val = {{16{cur_se & rdata[31]}}, rdata[31:16]};
            end
            default: lane_we = 4'b1111;
        endcase
        if (!(access && RST && cur_we && !acc_err)) begin
            lane_we = 4'b0000;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= 3'd0;
            we_q   <= 1'b0;
            se_q   <= 1'b0;
            size_q <= SZ_BYTE;
            addr_q <= '0;
            di_q   <= 32'h0;
            err_q  <= 1'b0;
            DO     <= 32'h0;
        end else begin
            if (load_fields) begin
                we_q   <= WE;
                se_q   <= SE;
                size_q <= SIZE;
                addr_q <= ADDR;
                di_q   <= DI;
                cnt    <= WS_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (access) begin
                err_q <= acc_err;
                if (acc_err) begin
                    DO <= 32'h0;
                end else if (!cur_we) begin
                    DO <= load_val;
                end
            end
        end
    end

    assign ACK  = (state == S_RESP);
    assign ERR  = ACK & err_q;
    assign BUSY = (state != S_IDLE);

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (CLK),
        .addr    (cur_addr),
        .lane_we (lane_we),
        .wdata   (wdata),
        .rdata   (rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (1, 0 and 3 wait states) driven with
// directed and random loads/stores and compared against a byte-array model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        req   [3];
    logic        we    [3];
    logic [1:0]  size  [3];
    logic        se    [3];
    logic [7:0]  addr  [3];
    logic [31:0] di    [3];
    logic        ack   [3];
    logic        err   [3];
    logic [31:0] dout  [3];
    logic        busy  [3];

    logic [7:0]  ref_mem [3][256];
    logic [31:0] ref_do  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : dut_gen
        data_mem_responder #(
            .ADDR_W      (8),
            .DEPTH       (256),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .CLK  (clk),
            .RST  (rst_n[g]),
            .REQ  (req[g]),
            .WE   (we[g]),
            .SIZE (size[g]),
            .SE   (se[g]),
            .ADDR (addr[g]),
            .DI   (di[g]),
            .ACK  (ack[g]),
            .ERR  (err[g]),
            .DO   (dout[g]),
            .BUSY (busy[g])
        );
    end

    function automatic int ws_of(input int idx);
        return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int idx);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ref_mem[idx][i] = v;
            case (idx)
                0:       dut_gen[0].u_dut.u_array.mem[i] <= v;
                1:       dut_gen[1].u_dut.u_array.mem[i] <= v;
                default: dut_gen[2].u_dut.u_array.mem[i] <= v;
            endcase
        end
    endtask

    // Reference: n = 2**size bytes; reject size 3 or addr not a multiple of n.
    task automatic model_access(input int idx, input logic w, input logic [1:0] sz, input logic s,
                                input logic [7:0] a, input logic [31:0] d, output logic e);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        e = (sz == 2'd3) || ((int'(a) % n) != 0);
        if (e) begin
            ref_do[idx] = 32'h0;
        end else if (w) begin
            for (int i = 0; i < n; i++) ref_mem[idx][int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[idx][int'(a) + i]);
            if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            ref_do[idx] = v;
        end
    endtask

    // Called at a negedge; lat is the expected number of negedges until ACK.
    task automatic applyStimulus(input int idx, input logic w, input logic [1:0] sz, input logic s,
                                 input logic [7:0] a, input logic [31:0] d, input int lat, input logic keep);
        logic e;
        int   k;
        logic seen;
        req[idx] = 1'b1; we[idx] = w; size[idx] = sz; se[idx] = s; addr[idx] = a; di[idx] = d;
        model_access(idx, w, sz, s, a, d, e);
        k = 0;
        seen = 1'b0;
        while (!seen && k < lat + 4) begin
            @(negedge clk);
            k++;
            if (ack[idx]) seen = 1'b1;
        end
        checkOutput($sformatf("ack_latency[%0d]", idx), k, lat);
        checkOutput($sformatf("err[%0d]", idx), {31'b0, err[idx]}, {31'b0, e});
        checkOutput($sformatf("do[%0d]", idx), dout[idx], ref_do[idx]);
        checkOutput($sformatf("busy_at_ack[%0d]", idx), {31'b0, busy[idx]}, 32'd1);
        if (!keep) begin
            req[idx] = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("ack_one_cycle[%0d]", idx), {31'b0, ack[idx]}, 32'd0);
            checkOutput($sformatf("err_idle[%0d]", idx), {31'b0, err[idx]}, 32'd0);
            checkOutput($sformatf("busy_idle[%0d]", idx), {31'b0, busy[idx]}, 32'd0);
        end
    endtask

    initial begin
        int  acks;
        int  k;
        logic seen;
        logic [1:0] sz;
        logic [7:0] a;

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; size[i] = 2'b00;
            se[i] = 1'b0; addr[i] = 8'h0; di[i] = 32'h0; ref_do[i] = 32'h0;
            preload(i);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_ack[%0d]", i), {31'b0, ack[i]}, 32'd0);
            checkOutput($sformatf("rst_err[%0d]", i), {31'b0, err[i]}, 32'd0);
            checkOutput($sformatf("rst_do[%0d]", i), dout[i], 32'h0);
            checkOutput($sformatf("rst_busy[%0d]", i), {31'b0, busy[i]}, 32'd0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);

        $display("[TB] directed: one wait state");
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 2, 1'b0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 1'b0);
        checkOutput("word_load_const", dout[0], 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 8'h11, 32'h0, 2, 1'b0);
        checkOutput("byte_se_const", dout[0], 32'hFFFFFFAD);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 8'h11, 32'h0, 2, 1'b0);
        checkOutput("byte_ze_const", dout[0], 32'h000000AD);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 2, 1'b0);
        checkOutput("half_se_const", dout[0], 32'hFFFFBEEF);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 8'h13, 32'h0, 2, 1'b0);
        applyStimulus(0, 1'b1, 2'b11, 1'b0, 8'h10, 32'h12345678, 2, 1'b0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2, 1'b0);
        checkOutput("mem_unchanged_const", dout[0], 32'hDEADBEEF);

        $display("[TB] directed: zero wait states back-to-back");
        applyStimulus(1, 1'b1, 2'b00, 1'b0, 8'h20, 32'h0000005A, 1, 1'b1);
        applyStimulus(1, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 2, 1'b0);
        checkOutput("b2b_load_const", dout[1], 32'h0000005A);

        $display("[TB] directed: reset during WAIT and RESP");
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 8'h2C, 32'h0, 4, 1'b0);
        req[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b00; se[2] = 1'b0; addr[2] = 8'h30;
        di[2] = {24'h0, ~ref_mem[2][8'h30]};
        @(negedge clk);
        checkOutput("wait_busy", {31'b0, busy[2]}, 32'd1);
        @(negedge clk);
        rst_n[2] = 1'b0;
        req[2] = 1'b0;
        #1;
        ref_do[2] = 32'h0;
        checkOutput("wait_rst_ack", {31'b0, ack[2]}, 32'd0);
        checkOutput("wait_rst_err", {31'b0, err[2]}, 32'd0);
        checkOutput("wait_rst_do", dout[2], 32'h0);
        checkOutput("wait_rst_busy", {31'b0, busy[2]}, 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        checkOutput("no_ack_after_rst", acks, 0);
        applyStimulus(2, 1'b0, 2'b00, 1'b0, 8'h30, 32'h0, 4, 1'b0);

        req[2] = 1'b1; we[2] = 1'b0; size[2] = 2'b10; se[2] = 1'b0; addr[2] = 8'h30; di[2] = 32'h0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (ack[2]) seen = 1'b1;
        end
        checkOutput("resp_ack_seen", {31'b0, seen}, 32'd1);
        req[2] = 1'b0;
        rst_n[2] = 1'b0;
        #1;
        checkOutput("resp_rst_ack", {31'b0, ack[2]}, 32'd0);
        checkOutput("resp_rst_err", {31'b0, err[2]}, 32'd0);
        checkOutput("resp_rst_do", dout[2], 32'h0);
        ref_do[2] = 32'h0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        @(negedge clk);

        $display("[TB] random traffic");
        for (int idx = 0; idx < 3; idx++) begin
            for (int t = 0; t < 40; t++) begin
                sz = 2'($urandom_range(0, 3));
                a  = 8'($urandom_range(0, 255));
                if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
                applyStimulus(idx, 1'($urandom), sz, 1'($urandom), a, $urandom, ws_of(idx) + 1, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
